// File: rtl/id_ex_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the ID/EX stage register, its load-use detector and
// the bus interface.
//   CTRL_W           width of the decoded control bundle
//   CTRL_*           bit positions inside the control bundle
//                    {regWrite, memRead, memWrite, memToReg, aluSrc, aluOp[1:0]}
//   aluop_e          ALU operation encodings
//   REG_ZERO         hard-wired zero register
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int CTRL_W          = 7;
    localparam int CTRL_REG_WRITE  = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_ALUOP_HI   = 1;
    localparam int CTRL_ALUOP_LO   = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } aluop_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // True when the control bundle describes a load (reads data memory).
    function automatic logic ctrl_is_load(input ctrl_t ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_if
// Bus between the decode stage / pipeline control and the ID/EX register.
//   master : drives the ID-side fields, hold and flush; observes the
//            registered EX-side fields, stall and the stall counter
//   slave  : the ID/EX register itself (mirror directions)
// ---------------------------------------------------------------------------
interface id_ex_stage_reg_if
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);

    logic              hold_i;
    logic              flush_i;
    logic [REG_W-1:0]  IF_IDregisterRs;
    logic [REG_W-1:0]  IF_IDregisterRt;
    logic              IF_IDusesRt;
    logic              id_valid_i;
    logic [REG_W-1:0]  id_rd_i;
    logic [DATA_W-1:0] id_rdata1_i;
    logic [DATA_W-1:0] id_rdata2_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [CTRL_W-1:0] id_ctrl_i;

    logic              stall_o;
    logic              ID_EXvalid;
    logic [REG_W-1:0]  ID_EXregisterRs;
    logic [REG_W-1:0]  ID_EXregisterRt;
    logic [REG_W-1:0]  ID_EXregisterRd;
    logic [DATA_W-1:0] ID_EXrdata1;
    logic [DATA_W-1:0] ID_EXrdata2;
    logic [DATA_W-1:0] ID_EXimm;
    logic [CTRL_W-1:0] ID_EXctrl;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output hold_i, flush_i, IF_IDregisterRs, IF_IDregisterRt, IF_IDusesRt,
               id_valid_i, id_rd_i, id_rdata1_i, id_rdata2_i, id_imm_i, id_ctrl_i,
        input  stall_o, ID_EXvalid, ID_EXregisterRs, ID_EXregisterRt, ID_EXregisterRd,
               ID_EXrdata1, ID_EXrdata2, ID_EXimm, ID_EXctrl, stall_cnt_o
    );

    modport slave (
        input  hold_i, flush_i, IF_IDregisterRs, IF_IDregisterRt, IF_IDusesRt,
               id_valid_i, id_rd_i, id_rdata1_i, id_rdata2_i, id_imm_i, id_ctrl_i,
        output stall_o, ID_EXvalid, ID_EXregisterRs, ID_EXregisterRt, ID_EXregisterRd,
               ID_EXrdata1, ID_EXrdata2, ID_EXimm, ID_EXctrl, stall_cnt_o
    );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// ---------------------------------------------------------------------------
// load_use_detector
// Purely combinational load-use hazard check between the instruction held in
// EX (the ID/EX register contents) and the instruction currently in ID.
//   ex_valid, ex_mem_read, ex_rd : EX instruction is a real load writing ex_rd
//   id_rs, id_rt, id_uses_rt     : ID source registers (rt only when read)
//   id_valid                     : ID holds a real instruction
//   hazard                       : ID must wait one cycle for the load data
// ---------------------------------------------------------------------------
module load_use_detector
    import pipeline_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_valid,
    output logic             hazard
);

    logic ex_is_load_s;
    logic src_match_s;

    // Load in EX with a real destination, and ID reads that destination.
    // A zero destination never matches, so register 0 as a source is also safe.
    always_comb begin
        ex_is_load_s = 1'b0;
        src_match_s  = 1'b0;
        hazard       = 1'b0;
        if (ex_valid && ex_mem_read && (ex_rd != REG_W'(REG_ZERO))) begin
            ex_is_load_s = 1'b1;
        end else begin
            ex_is_load_s = 1'b0;
        end
        if ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt))) begin
            src_match_s = 1'b1;
        end else begin
            src_match_s = 1'b0;
        end
        if (ex_is_load_s && src_match_s && id_valid) begin
            hazard = 1'b1;
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register with load-use hazard detection.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : id_ex_stage_reg_if.slave
//          in  : hold_i, flush_i, IF_ID rs/rt/usesRt, id_valid_i, id_rd_i,
//                id_rdata1_i, id_rdata2_i, id_imm_i, id_ctrl_i
//          out : stall_o (combinational), registered ID_EX* fields,
//                stall_cnt_o (saturating bubble count)
// Edge priority: rst > hold > flush > hazard > capture.
// ---------------------------------------------------------------------------
module id_ex_stage_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    id_ex_stage_reg_if.slave bus
);

    // Five single-bit control flags plus the ALU operation field.
    localparam int CTRL_BITS = 5 + ALUOP_W;

    logic                 valid_r;
    logic [REG_W-1:0]     rs_r;
    logic [REG_W-1:0]     rt_r;
    logic [REG_W-1:0]     rd_r;
    logic [DATA_W-1:0]    rdata1_r;
    logic [DATA_W-1:0]    rdata2_r;
    logic [DATA_W-1:0]    imm_r;
    logic [CTRL_BITS-1:0] ctrl_r;
    logic [CNT_W-1:0]     cnt_r;

    logic                 hazard_s;
    logic                 stall_s;

    load_use_detector #(
        .REG_W (REG_W)
    ) u_load_use_detector (
        .ex_valid    (valid_r),
        .ex_mem_read (ctrl_is_load(ctrl_r)),
        .ex_rd       (rd_r),
        .id_rs       (bus.IF_IDregisterRs),
        .id_rt       (bus.IF_IDregisterRt),
        .id_uses_rt  (bus.IF_IDusesRt),
        .id_valid    (bus.id_valid_i),
        .hazard      (hazard_s)
    );

    // A flush discards ID anyway, and during hold nothing moves, so neither stalls.
    always_comb begin
        stall_s = 1'b0;
        if (hazard_s && !bus.flush_i && !bus.hold_i) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Stage register and saturating bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= 1'b0;
            rs_r     <= '0;
            rt_r     <= '0;
            rd_r     <= '0;
            rdata1_r <= '0;
            rdata2_r <= '0;
            imm_r    <= '0;
            ctrl_r   <= '0;
            cnt_r    <= '0;
        end else if (bus.hold_i) begin
            // Frozen: all state retained; the hazard keeps being evaluated on it.
        end else if (bus.flush_i) begin
            valid_r  <= 1'b0;
            rs_r     <= '0;
            rt_r     <= '0;
            rd_r     <= '0;
            rdata1_r <= '0;
            rdata2_r <= '0;
            imm_r    <= '0;
            ctrl_r   <= '0;
        end else if (hazard_s) begin
            // Bubble clears memRead, so the same pair cannot stall twice.
            valid_r  <= 1'b0;
            rs_r     <= '0;
            rt_r     <= '0;
            rd_r     <= '0;
            rdata1_r <= '0;
            rdata2_r <= '0;
            imm_r    <= '0;
            ctrl_r   <= '0;
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            valid_r  <= bus.id_valid_i;
            rs_r     <= bus.IF_IDregisterRs;
            rt_r     <= bus.IF_IDregisterRt;
            rd_r     <= bus.id_rd_i;
            rdata1_r <= bus.id_rdata1_i;
            rdata2_r <= bus.id_rdata2_i;
            imm_r    <= bus.id_imm_i;
            // An empty ID slot must not carry write/memory side effects forward.
            ctrl_r   <= bus.id_valid_i ? bus.id_ctrl_i : {CTRL_BITS{1'b0}};
        end
    end

    assign bus.stall_o         = stall_s;
    assign bus.ID_EXvalid      = valid_r;
    assign bus.ID_EXregisterRs = rs_r;
    assign bus.ID_EXregisterRt = rt_r;
    assign bus.ID_EXregisterRd = rd_r;
    assign bus.ID_EXrdata1     = rdata1_r;
    assign bus.ID_EXrdata2     = rdata2_r;
    assign bus.ID_EXimm        = imm_r;
    assign bus.ID_EXctrl       = ctrl_r;
    assign bus.stall_cnt_o     = cnt_r;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Directed scenarios plus randomized traffic against a behavioural model of
// the ID/EX stage (state = the instruction sitting in EX plus a bubble count).
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;
    import pipeline_pkg::*;

    localparam logic [6:0] CTRL_LW  = 7'b1101100; // regWrite, memRead, memToReg, aluSrc, ADD
    localparam logic [6:0] CTRL_ADD = 7'b1000010; // regWrite, RTYPE

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus ();

    id_ex_stage_reg #(
        .DATA_W (32), .REG_W (5), .ALUOP_W (2), .CNT_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm;
        logic [6:0]  ctrl;
        logic [15:0] cnt;
    } st_t;

    st_t m;
    bit  known = 1'b0;
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // EX holds a real load with a nonzero target, and the ID instruction reads it.
    function automatic logic model_hazard(input st_t s);
        logic ex_load;
        logic reads;
        ex_load = s.valid && s.ctrl[5] && (s.rd != 5'd0);
        reads   = (bus.IF_IDregisterRs == s.rd) || (bus.IF_IDusesRt && (bus.IF_IDregisterRt == s.rd));
        return ex_load && reads && bus.id_valid_i;
    endfunction

    function automatic st_t model_next(input st_t s);
        st_t n;
        n = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, d1: 32'd0, d2: 32'd0,
              imm: 32'd0, ctrl: 7'd0, cnt: s.cnt};
        if (rst) begin
            n.cnt = 16'd0;
        end else if (bus.hold_i) begin
            n = s;
        end else if (bus.flush_i) begin
            n.cnt = s.cnt;
        end else if (model_hazard(s)) begin
            n.cnt = (s.cnt == 16'hFFFF) ? s.cnt : s.cnt + 16'd1;
        end else begin
            n.valid = bus.id_valid_i;
            n.rs    = bus.IF_IDregisterRs;
            n.rt    = bus.IF_IDregisterRt;
            n.rd    = bus.id_rd_i;
            n.d1    = bus.id_rdata1_i;
            n.d2    = bus.id_rdata2_i;
            n.imm   = bus.id_imm_i;
            n.ctrl  = bus.id_valid_i ? bus.id_ctrl_i : 7'd0;
        end
        return n;
    endfunction

    task automatic compare_state();
        chk("valid", {31'd0, bus.ID_EXvalid}, {31'd0, m.valid});
        chk("rs",    {27'd0, bus.ID_EXregisterRs}, {27'd0, m.rs});
        chk("rt",    {27'd0, bus.ID_EXregisterRt}, {27'd0, m.rt});
        chk("rd",    {27'd0, bus.ID_EXregisterRd}, {27'd0, m.rd});
        chk("rdata1", bus.ID_EXrdata1, m.d1);
        chk("rdata2", bus.ID_EXrdata2, m.d2);
        chk("imm",    bus.ID_EXimm, m.imm);
        chk("ctrl",  {25'd0, bus.ID_EXctrl}, {25'd0, m.ctrl});
        chk("stall_cnt", {16'd0, bus.stall_cnt_o}, {16'd0, m.cnt});
    endtask

    // One clock: check combinational stall, advance the model, check registers.
    task automatic step();
        st_t nxt;
        #1;
        if (known) begin
            chk("stall", {31'd0, bus.stall_o},
                {31'd0, model_hazard(m) && !bus.flush_i && !bus.hold_i});
        end
        nxt = model_next(m);
        @(posedge clk);
        #1;
        if (rst) known = 1'b1;
        m = nxt;
        if (known) compare_state();
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic valid, input logic [4:0] rd, input logic [6:0] ctrl,
                         input logic hold, input logic flush);
        bus.IF_IDregisterRs = rs;
        bus.IF_IDregisterRt = rt;
        bus.IF_IDusesRt     = uses_rt;
        bus.id_valid_i      = valid;
        bus.id_rd_i         = rd;
        bus.id_rdata1_i     = $urandom;
        bus.id_rdata2_i     = $urandom;
        bus.id_imm_i        = $urandom;
        bus.id_ctrl_i       = ctrl;
        bus.hold_i          = hold;
        bus.flush_i         = flush;
        #1;
    endtask

    task automatic drive_rand();
        logic [6:0] c;
        c = 7'($urandom);
        drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
              ($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), c,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    endtask

    // Load into rd, then present a dependent instruction reading rd as rs.
    task automatic load_then_dep(input logic [4:0] rd);
        drive(5'd1, 5'd2, 1'b0, 1'b1, rd, CTRL_LW, 1'b0, 1'b0);
        step();
        drive(rd, 5'd3, 1'b1, 1'b1, 5'd9, CTRL_ADD, 1'b0, 1'b0);
    endtask

    initial begin
        m = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, d1: 32'd0, d2: 32'd0,
              imm: 32'd0, ctrl: 7'd0, cnt: 16'd0};

        // Reset with random inputs.
        rst = 1'b1;
        drive_rand();
        step();
        drive_rand();
        step();
        chk("rst_valid", {31'd0, bus.ID_EXvalid}, 32'd0);
        chk("rst_ctrl", {25'd0, bus.ID_EXctrl}, 32'd0);
        chk("rst_cnt", {16'd0, bus.stall_cnt_o}, 32'd0);
        chk("rst_rdata1", bus.ID_EXrdata1, 32'd0);
        rst = 1'b0;

        // Load-use on rs: one bubble, then the add is captured.
        drive(5'd2, 5'd8, 1'b0, 1'b1, 5'd8, CTRL_LW, 1'b0, 1'b0);
        step();
        chk("lw_ctrl", {25'd0, bus.ID_EXctrl}, {25'd0, CTRL_LW});
        drive(5'd8, 5'd3, 1'b1, 1'b1, 5'd9, CTRL_ADD, 1'b0, 1'b0);
        chk("lu_stall", {31'd0, bus.stall_o}, 32'd1);
        step();
        chk("bubble_valid", {31'd0, bus.ID_EXvalid}, 32'd0);
        chk("bubble_ctrl", {25'd0, bus.ID_EXctrl}, 32'd0);
        chk("bubble_cnt", {16'd0, bus.stall_cnt_o}, 32'd1);
        chk("after_bubble_stall", {31'd0, bus.stall_o}, 32'd0);
        step();
        chk("add_valid", {31'd0, bus.ID_EXvalid}, 32'd1);
        chk("add_rs", {27'd0, bus.ID_EXregisterRs}, 32'd8);
        chk("add_rd", {27'd0, bus.ID_EXregisterRd}, 32'd9);

        // Register 0 never stalls; unread rt never stalls.
        load_then_dep(5'd0);
        chk("r0_stall", {31'd0, bus.stall_o}, 32'd0);
        step();
        chk("r0_valid", {31'd0, bus.ID_EXvalid}, 32'd1);
        drive(5'd1, 5'd2, 1'b0, 1'b1, 5'd5, CTRL_LW, 1'b0, 1'b0);
        step();
        drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd9, CTRL_ADD, 1'b0, 1'b0);
        chk("rt_unused_stall", {31'd0, bus.stall_o}, 32'd0);
        bus.IF_IDusesRt = 1'b1;
        #1;
        chk("rt_used_stall", {31'd0, bus.stall_o}, 32'd1);
        step();
        chk("rt_bubble_cnt", {16'd0, bus.stall_cnt_o}, 32'd2);

        // Flush wins over the hazard: bubble, counter unchanged.
        load_then_dep(5'd7);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_stall", {31'd0, bus.stall_o}, 32'd0);
        step();
        chk("flush_valid", {31'd0, bus.ID_EXvalid}, 32'd0);
        chk("flush_cnt", {16'd0, bus.stall_cnt_o}, 32'd2);

        // Hold for 3 cycles during a hazard, then release.
        load_then_dep(5'd6);
        bus.hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", {31'd0, bus.stall_o}, 32'd0);
            step();
            chk("hold_ctrl", {25'd0, bus.ID_EXctrl}, {25'd0, CTRL_LW});
            chk("hold_rd", {27'd0, bus.ID_EXregisterRd}, 32'd6);
            chk("hold_cnt", {16'd0, bus.stall_cnt_o}, 32'd2);
        end
        bus.hold_i = 1'b0;
        #1;
        chk("release_stall", {31'd0, bus.stall_o}, 32'd1);
        step();
        chk("release_valid", {31'd0, bus.ID_EXvalid}, 32'd0);
        chk("release_cnt", {16'd0, bus.stall_cnt_o}, 32'd3);

        // Reset while stalling.
        load_then_dep(5'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst_mid_valid", {31'd0, bus.ID_EXvalid}, 32'd0);
        chk("rst_mid_cnt", {16'd0, bus.stall_cnt_o}, 32'd0);

        // Saturation: preload near the top, then two more hazards.
        force dut.cnt_r = 16'hFFFE;
        #1;
        release dut.cnt_r;
        m.cnt = 16'hFFFE;
        load_then_dep(5'd10);
        step();
        chk("sat_reach", {16'd0, bus.stall_cnt_o}, 32'h0000FFFF);
        load_then_dep(5'd11);
        step();
        chk("sat_hold", {16'd0, bus.stall_cnt_o}, 32'h0000FFFF);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive_rand();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
